// File: rtl/m_controller.sv
// Sequencing FSM for the M-extension unit: steps the remainder/divisor/quotient
// mux selects through load, iterate and capture, and decodes result forwarding.
module m_controller #(
    parameter int MUL_LATENCY = 1
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic [2:0] funct3,
    input  logic       rs1_sign,
    input  logic       rs2_sign,
    input  logic       rs2_zero,
    input  logic       flush,
    input  logic       sub_neg,
    output logic [2:0] mux_R,
    output logic [1:0] mux_D,
    output logic [1:0] mux_Z,
    output logic       mult_a_signed,
    output logic       mult_b_signed,
    output logic       busy,
    output logic       done,
    output logic [1:0] res_sel,
    output logic       res_neg
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ITER,
        S_MWAIT,
        S_MCAP,
        S_DONE
    } state_t;

    localparam logic [2:0] R_KEEP       = 3'd0;
    localparam logic [2:0] R_A          = 3'd1;
    localparam logic [2:0] R_A_NEG      = 3'd2;
    localparam logic [2:0] R_SUB_KEEP   = 3'd3;
    localparam logic [2:0] R_MULT_LOWER = 3'd4;
    localparam logic [1:0] D_KEEP       = 2'd0;
    localparam logic [1:0] D_B          = 2'd1;
    localparam logic [1:0] D_B_NEG      = 2'd2;
    localparam logic [1:0] D_SHR        = 2'd3;
    localparam logic [1:0] Z_KEEP       = 2'd0;
    localparam logic [1:0] Z_ZERO       = 2'd1;
    localparam logic [1:0] Z_SHL_ADD    = 2'd2;
    localparam logic [1:0] Z_MULT_UPPER = 2'd3;
    localparam logic [1:0] SEL_Z        = 2'd0;
    localparam logic [1:0] SEL_R        = 2'd1;
    localparam logic [1:0] SEL_ONES     = 2'd2;

    // The iteration counter doubles as the multiplier wait counter.
    localparam logic [4:0] WAIT_LAST = 5'(MUL_LATENCY - 2);

    state_t     state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic [2:0] op_q, op_d;
    logic       s1_q, s1_d;
    logic       s2_q, s2_d;
    logic       div0_q, div0_d;
    logic       res_valid_q, res_valid_d;
    logic       signed_op;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            div0_q      <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            div0_q      <= div0_d;
            res_valid_q <= res_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        s1_d        = s1_q;
        s2_d        = s2_q;
        div0_d      = div0_q;
        res_valid_d = res_valid_q;
        signed_op   = funct3[2] & ~funct3[0];

        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_d        = funct3;
                        s1_d        = rs1_sign & signed_op;
                        s2_d        = rs2_sign & signed_op;
                        div0_d      = rs2_zero;
                        res_valid_d = 1'b0;
                        cnt_d       = '0;
                        if (funct3[2]) begin
                            state_d = S_LOAD;
                        end else if (MUL_LATENCY > 1) begin
                            state_d = S_MWAIT;
                        end else begin
                            state_d = S_MCAP;
                        end
                    end
                end
                S_LOAD: begin
                    cnt_d = '0;
                    if (div0_q) begin
                        state_d     = S_DONE;
                        res_valid_d = 1'b1;
                    end else begin
                        state_d = S_ITER;
                    end
                end
                S_ITER: begin
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d     = S_DONE;
                        res_valid_d = 1'b1;
                    end
                end
                S_MWAIT: begin
                    if (cnt_q == WAIT_LAST) begin
                        state_d = S_MCAP;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
                S_MCAP: begin
                    state_d     = S_DONE;
                    res_valid_d = 1'b1;
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        mux_R         = R_KEEP;
        mux_D         = D_KEEP;
        mux_Z         = Z_KEEP;
        busy          = (state_q != S_IDLE);
        done          = (state_q == S_DONE);
        mult_a_signed = (state_q != S_IDLE) && ((op_q == 3'b001) || (op_q == 3'b010));
        mult_b_signed = (state_q != S_IDLE) && (op_q == 3'b001);
        res_sel       = SEL_Z;
        res_neg       = 1'b0;

        case (state_q)
            S_LOAD: begin
                mux_R = s1_q ? R_A_NEG : R_A;
                mux_D = s2_q ? D_B_NEG : D_B;
                mux_Z = Z_ZERO;
            end
            S_ITER: begin
                mux_R = R_SUB_KEEP;
                mux_D = D_SHR;
                mux_Z = Z_SHL_ADD;
            end
            S_MCAP: begin
                mux_R = R_MULT_LOWER;
                mux_Z = Z_MULT_UPPER;
            end
            default: begin
            end
        endcase

        // Result forwarding stays at its reset value until the first completion.
        if (res_valid_q) begin
            case (op_q)
                3'b000: res_sel = SEL_R;
                3'b100, 3'b101: begin
                    res_sel = div0_q ? SEL_ONES : SEL_Z;
                    res_neg = (s1_q ^ s2_q) & ~div0_q;
                end
                3'b110, 3'b111: begin
                    res_sel = SEL_R;
                    res_neg = s1_q;
                end
                default: res_sel = SEL_Z;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (resetn && state_q == S_ITER) begin
            assert (!$isunknown(sub_neg));
        end
    end

endmodule

// File: tb/tb_m_controller.sv
// Self-checking bench for m_controller: directed scenarios followed by random
// traffic, all compared cycle by cycle against an operation-level model.
module tb_m_controller;

    localparam int MUL_LAT = 3;

    logic       clk;
    logic       resetn;
    logic       start;
    logic [2:0] funct3;
    logic       rs1_sign;
    logic       rs2_sign;
    logic       rs2_zero;
    logic       flush;
    logic       sub_neg;
    logic [2:0] mux_R;
    logic [1:0] mux_D;
    logic [1:0] mux_Z;
    logic       mult_a_signed;
    logic       mult_b_signed;
    logic       busy;
    logic       done;
    logic [1:0] res_sel;
    logic       res_neg;

    int checks = 0;
    int errors = 0;

    // Operation-level model: which cycle of which operation we are in.
    logic       m_active = 1'b0;
    int         m_k = 0;
    int         m_n = 0;
    logic [2:0] m_op = '0;
    logic       m_r1 = 1'b0;
    logic       m_r2 = 1'b0;
    logic       m_z = 1'b0;
    logic       m_res_known = 1'b0;
    logic [2:0] m_res = '0;

    m_controller #(.MUL_LATENCY(MUL_LAT)) dut (
        .clk(clk),
        .resetn(resetn),
        .start(start),
        .funct3(funct3),
        .rs1_sign(rs1_sign),
        .rs2_sign(rs2_sign),
        .rs2_zero(rs2_zero),
        .flush(flush),
        .sub_neg(sub_neg),
        .mux_R(mux_R),
        .mux_D(mux_D),
        .mux_Z(mux_Z),
        .mult_a_signed(mult_a_signed),
        .mult_b_signed(mult_b_signed),
        .busy(busy),
        .done(done),
        .res_sel(res_sel),
        .res_neg(res_neg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycles from acceptance to the done cycle inclusive.
    function automatic int op_len(input logic [2:0] op, input logic z);
        if (op[2]) return z ? 2 : 34;
        return MUL_LAT + 1;
    endfunction

    // {res_sel, res_neg} for a finished operation.
    function automatic logic [2:0] result_of(input logic [2:0] op, input logic r1,
                                             input logic r2, input logic z);
        logic sgn, s1, s2;
        sgn = (op == 3'b100) || (op == 3'b110);
        s1  = r1 & sgn;
        s2  = r2 & sgn;
        case (op)
            3'b000:         return {2'd1, 1'b0};
            3'b100, 3'b101: return {z ? 2'd2 : 2'd0, (s1 ^ s2) & ~z};
            3'b110, 3'b111: return {2'd1, s1};
            default:        return {2'd0, 1'b0};
        endcase
    endfunction

    // Expected packed outputs in cycle k (1..n) of an operation.
    function automatic logic [13:0] op_outputs(input logic [2:0] op, input logic r1,
                                               input logic r2, input logic z,
                                               input int k, input int n);
        logic [2:0] mr;
        logic [1:0] md, mz;
        logic       sgn;
        mr  = 3'd0;
        md  = 2'd0;
        mz  = 2'd0;
        sgn = (op == 3'b100) || (op == 3'b110);
        if (op[2]) begin
            if (k == 1) begin
                mr = (r1 & sgn) ? 3'd2 : 3'd1;
                md = (r2 & sgn) ? 2'd2 : 2'd1;
                mz = 2'd1;
            end else if (!z && k >= 2 && k <= 33) begin
                mr = 3'd3;
                md = 2'd3;
                mz = 2'd2;
            end
        end else if (k == n - 1) begin
            mr = 3'd4;
            mz = 2'd3;
        end
        return {mr, md, mz, (op == 3'b001) || (op == 3'b010), op == 3'b001,
                1'b1, k == n, result_of(op, r1, r2, z)};
    endfunction

    task automatic model_edge();
        if (!resetn) begin
            m_active    = 1'b0;
            m_res_known = 1'b1;
            m_res       = '0;
        end else if (flush) begin
            if (m_active) m_res_known = 1'b0;
            m_active = 1'b0;
        end else if (m_active) begin
            if (m_k == m_n) begin
                m_active    = 1'b0;
                m_res_known = 1'b1;
                m_res       = result_of(m_op, m_r1, m_r2, m_z);
            end else begin
                m_k++;
            end
        end else if (start) begin
            m_active    = 1'b1;
            m_k         = 1;
            m_op        = funct3;
            m_r1        = rs1_sign;
            m_r2        = rs2_sign;
            m_z         = rs2_zero;
            m_n         = op_len(funct3, rs2_zero);
            m_res_known = 1'b0;
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [13:0] obs, expv, mask;
        obs = {mux_R, mux_D, mux_Z, mult_a_signed, mult_b_signed, busy, done, res_sel, res_neg};
        if (m_active) begin
            expv = op_outputs(m_op, m_r1, m_r2, m_z, m_k, m_n);
            mask = (m_k == m_n) ? 14'h3FFF : 14'h3FF8;
        end else begin
            expv = {11'd0, m_res};
            mask = m_res_known ? 14'h3FFF : 14'h3FF8;
        end
        checks++;
        assert ((obs & mask) === (expv & mask)) else begin
            errors++;
            $error("FAIL %s op=%0d k=%0d observed=%h expected=%h", tag, m_op, m_k,
                   obs & mask, expv & mask);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic [2:0] f3, input logic r1,
                                 input logic r2, input logic z, input logic fl,
                                 input logic rn);
        start    = st;
        funct3   = f3;
        rs1_sign = r1;
        rs2_sign = r2;
        rs2_zero = z;
        flush    = fl;
        resetn   = rn;
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        checkOutput(tag);
    endtask

    initial begin
        sub_neg = 1'b0;
        applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick("reset");
        tick("reset");
        applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick("idle");

        $display("[TB] DIV with negative dividend");
        applyStimulus(1'b1, 3'b100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick("div_neg");
        applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (34) tick("div_neg");

        $display("[TB] divide by zero");
        applyStimulus(1'b1, 3'b110, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        tick("rem_zero");
        applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (2) tick("rem_zero");
        applyStimulus(1'b1, 3'b101, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        tick("divu_zero");
        applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (2) tick("divu_zero");

        $display("[TB] MULHSU");
        applyStimulus(1'b1, 3'b010, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        tick("mulhsu");
        applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (4) tick("mulhsu");

        $display("[TB] reset in the middle of a divide");
        applyStimulus(1'b1, 3'b101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick("rst_iter");
        applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (18) tick("rst_iter");
        applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick("rst_iter_reset");
        applyStimulus(1'b1, 3'b101, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        tick("divu_after_rst");
        applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (35) tick("divu_after_rst");

        $display("[TB] start held high");
        applyStimulus(1'b1, 3'b101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (40) tick("start_held");
        applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (32) tick("start_held");

        $display("[TB] flush with start during MCAP");
        applyStimulus(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick("flush_mcap");
        applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (2) tick("flush_mcap");
        applyStimulus(1'b1, 3'b100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick("flush_mcap_flush");
        applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (2) tick("flush_mcap_after");

        $display("[TB] random traffic");
        for (int i = 0; i < 2500; i++) begin
            sub_neg = 1'($urandom);
            applyStimulus($urandom_range(0, 5) == 0, 3'($urandom), 1'($urandom),
                          1'($urandom), $urandom_range(0, 3) == 0,
                          $urandom_range(0, 79) == 0, $urandom_range(0, 399) != 0);
            tick("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
